mem_arbiter: RTL and testbench

- Sits directly downstream of the icache and the dcache. It owns the single-ported RAM port and arbitrates between the icache's instruction-fill reads and the dcache's reads and writes.
- It produces the iwait/iload and dwait/dload responses the caches consume.
- Dcache has priority. A starvation counter forces an icache grant after a bounded number of consecutive dcache wins.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Word type and RAM port status encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for icache fills and dcache accesses.
// Dcache wins unless the icache has been starved STARVE_MAX times.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;

  logic d_req;
  logic acc;

  assign d_req = dREN | dWEN;
  assign acc   = (ramstate == ACCESS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(iREN && starve_q == SMAX)) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        // A dropped request abandons the grant even if ACCESS arrives
        if (!iREN) begin
          state_d = IDLE;
        end else if (acc) begin
          iwait    = 1'b0;
          iload    = ramload;
          state_d  = IDLE;
          starve_d = 4'd0;
        end
      end
      DGRANT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          state_d = IDLE;
        end else if (acc) begin
          dwait   = 1'b0;
          dload   = dREN ? ramload : '0;
          state_d = IDLE;
          if (!iREN) begin
            starve_d = 4'd0;
          end else if (starve_q != SMAX) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset cycle: nothing reaches the RAM and no completion escapes
    if (RST) begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Transaction-level ownership model plus literal spot checks.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SM = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  ramstate_t   ramstate;

  int errors = 0;
  int checks = 0;

  int m_own = 0;
  int m_starve = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Ownership model: 0 = nobody, 1 = icache, 2 = dcache
  always @(posedge CLK) begin
    if (RST) begin
      m_own = 0;
      m_starve = 0;
    end else if (m_own == 0) begin
      if ((dREN || dWEN) && !(iREN && m_starve == SM)) m_own = 2;
      else if (iREN) m_own = 1;
    end else if (m_own == 1) begin
      if (!iREN) m_own = 0;
      else if (ramstate == ACCESS) begin
        m_own = 0;
        m_starve = 0;
      end
    end else begin
      if (!(dREN || dWEN)) m_own = 0;
      else if (ramstate == ACCESS) begin
        m_own = 0;
        m_starve = iREN ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
      end
    end
  end

  always @(negedge CLK) begin
    logic        e_iw, e_dw, e_rr, e_rw;
    logic [31:0] e_il, e_dl, e_ra, e_rs;
    e_iw = 1; e_dw = 1; e_rr = 0; e_rw = 0;
    e_il = 0; e_dl = 0; e_ra = 0; e_rs = 0;
    if (!RST && m_own == 1) begin
      e_rr = 1;
      e_ra = iaddr;
      if (iREN && ramstate == ACCESS) begin
        e_iw = 0;
        e_il = ramload;
      end
    end else if (!RST && m_own == 2) begin
      e_rr = dREN;
      e_rw = dWEN;
      e_ra = daddr;
      e_rs = dstore;
      if ((dREN || dWEN) && ramstate == ACCESS) begin
        e_dw = 0;
        e_dl = dREN ? ramload : 32'h0;
      end
    end
    chk("iwait", {31'b0, iwait}, {31'b0, e_iw});
    chk("dwait", {31'b0, dwait}, {31'b0, e_dw});
    chk("ramREN", {31'b0, ramREN}, {31'b0, e_rr});
    chk("ramWEN", {31'b0, ramWEN}, {31'b0, e_rw});
    chk("iload", iload, e_il);
    chk("dload", dload, e_dl);
    chk("ramaddr", ramaddr, e_ra);
    chk("ramstore", ramstore, e_rs);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1; iREN = 1; dREN = 0; dWEN = 0;
    iaddr = 32'h40; daddr = 0; dstore = 0;
    ramload = 32'hDEADBEEF; ramstate = BUSY;

    // reset held two edges with iREN pending
    tick();
    mid();
    chk("rst_iwait", {31'b0, iwait}, 32'd1);
    chk("rst_ramaddr", ramaddr, 32'h0);
    tick();
    RST = 0;
    mid();
    chk("post_rst_idle", {31'b0, ramREN}, 32'd0);

    // icache read, 2 BUSY then ACCESS
    tick();
    mid();
    chk("i_busy1_ren", {31'b0, ramREN}, 32'd1);
    chk("i_busy1_addr", ramaddr, 32'h40);
    tick();
    mid();
    chk("i_busy2_iwait", {31'b0, iwait}, 32'd1);
    tick();
    ramstate = ACCESS;
    mid();
    chk("i_acc_iwait", {31'b0, iwait}, 32'd0);
    chk("i_acc_iload", iload, 32'hDEADBEEF);
    tick();
    iREN = 0; ramstate = FREE;
    mid();
    chk("i_done_idle", {31'b0, ramREN}, 32'd0);

    // simultaneous iREN and dWEN: dcache first
    iREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
    ramload = 32'hCAFEF00D;
    tick();
    ramstate = ACCESS;
    mid();
    chk("d_wr_wen", {31'b0, ramWEN}, 32'd1);
    chk("d_wr_store", ramstore, 32'h1234);
    chk("d_wr_dwait", {31'b0, dwait}, 32'd0);
    chk("d_wr_dload", dload, 32'h0);
    tick();
    dWEN = 0; ramstate = FREE;
    tick();
    ramstate = ACCESS;
    mid();
    chk("i_after_d_addr", ramaddr, 32'h40);
    chk("i_after_d_iload", iload, 32'hCAFEF00D);
    tick();
    iREN = 0; ramstate = FREE;

    // starvation: dcache reads back to back with iREN held
    iREN = 1; dREN = 1; daddr = 32'h100; ramstate = ACCESS;
    for (int k = 0; k < SM; k++) begin
      ramload = 32'h11110000 + k;
      tick();
      mid();
      chk("starve_d_dwait", {31'b0, dwait}, 32'd0);
      chk("starve_d_dload", dload, 32'h11110000 + k);
      tick();
    end
    tick();
    mid();
    chk("starve_i_forced", {31'b0, iwait}, 32'd0);
    chk("starve_i_dwait", {31'b0, dwait}, 32'd1);
    tick();
    tick();
    mid();
    chk("starve_cleared_d", {31'b0, dwait}, 32'd0);
    tick();
    iREN = 0; dREN = 0; ramstate = FREE;

    // icache abort while BUSY
    iREN = 1; ramstate = BUSY;
    tick();
    mid();
    chk("abort_ren", {31'b0, ramREN}, 32'd1);
    tick();
    iREN = 0;
    mid();
    chk("abort_iwait", {31'b0, iwait}, 32'd1);
    tick();
    mid();
    chk("abort_idle", {31'b0, ramREN}, 32'd0);
    ramstate = FREE;

    // ERROR treated as BUSY during a dcache read
    dREN = 1; daddr = 32'h200; ramload = 32'h5A5A5A5A; ramstate = ERROR;
    for (int k = 0; k < 3; k++) begin
      tick();
      mid();
      chk("err_dwait", {31'b0, dwait}, 32'd1);
      chk("err_dload", dload, 32'h0);
    end
    tick();
    ramstate = ACCESS;
    mid();
    chk("err_acc_dwait", {31'b0, dwait}, 32'd0);
    chk("err_acc_dload", dload, 32'h5A5A5A5A);
    tick();
    dREN = 0; ramstate = FREE;

    // reset during a dcache grant
    dREN = 1; daddr = 32'h300; ramstate = BUSY;
    tick();
    mid();
    chk("rst_mid_grant", {31'b0, ramREN}, 32'd1);
    tick();
    RST = 1; ramstate = ACCESS;
    mid();
    chk("rst_mid_dwait", {31'b0, dwait}, 32'd1);
    chk("rst_mid_ramaddr", ramaddr, 32'h0);
    tick();
    RST = 0; dREN = 0; ramstate = FREE;
    mid();
    chk("rst_mid_idle_ren", {31'b0, ramREN}, 32'd0);
    chk("rst_mid_idle_dwait", {31'b0, dwait}, 32'd1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
